// File: rtl/mult_pkg.sv
// Shared widths and helpers for the saturating sequential multiplier.
package mult_pkg;

  // Default operand and product widths.
  localparam int unsigned DEF_A_W = 3;
  localparam int unsigned DEF_B_W = 3;
  localparam int unsigned DEF_P_W = 5;

  // Width of the full, unsaturated product at the default operand widths.
  localparam int unsigned FULL_W = DEF_A_W + DEF_B_W;

  // Largest value representable in p_w unsigned bits (2^p_w - 1), for p_w up to 32.
  function automatic logic [31:0] sat_max(input int unsigned p_w);
    logic [32:0] one_hot;
    one_hot = 33'(1) << p_w;
    return 32'(one_hot - 33'd1);
  endfunction

endpackage

// File: rtl/mult_pp_array.sv
// Combinational unsigned multiplier core.
// It ANDs operand a with each bit of b to form the partial products, shifts each one into
// place, and sums them with a chain of ripple-carry adders. There is no '*' operator.
module mult_pp_array
  import mult_pkg::*;
#(
  parameter int unsigned A_W = DEF_A_W,
  parameter int unsigned B_W = DEF_B_W
) (
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] p
);

  localparam int unsigned PROD_W = A_W + B_W;

  logic [PROD_W-1:0] w_pp [B_W];

  // Partial product i is a gated by b[i], zero-extended and shifted left by i.
  for (genvar i = 0; i < B_W; i++) begin : g_pp
    assign w_pp[i] = {{B_W{1'b0}}, (a & {A_W{b[i]}})} << i;
  end

  // Ripple-add chain: each stage adds one partial product into the running sum bit by bit.
  // The carry out of the top bit is always zero because a*b fits in PROD_W bits, so it is
  // never formed.
  always_comb begin
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] nxt;
    logic              carry;
    acc   = '0;
    nxt   = '0;
    carry = 1'b0;
    for (int i = 0; i < B_W; i++) begin
      carry = 1'b0;
      for (int j = 0; j < PROD_W; j++) begin
        nxt[j] = acc[j] ^ w_pp[i][j] ^ carry;
        carry  = (acc[j] & w_pp[i][j]) | (carry & (acc[j] ^ w_pp[i][j]));
      end
      acc = nxt;
    end
    p = acc;
  end

endmodule

// File: rtl/seq_multiplier.sv
// Registered unsigned multiplier with saturation.
// The core forms the full product of a and b. The output clamps to all ones when that
// product does not fit in P_W bits, and ovf flags the clamp for that result only.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned A_W = DEF_A_W,
  parameter int unsigned B_W = DEF_B_W,
  parameter int unsigned P_W = DEF_P_W  // 1 <= P_W <= A_W+B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] c,
  output logic           ovf
);

  localparam int unsigned       PROD_W  = A_W + B_W;
  localparam logic [PROD_W-1:0] SAT_MAX = PROD_W'(sat_max(P_W));

  logic [PROD_W-1:0] w_p;
  logic [P_W-1:0]    w_c;
  logic              w_ovf;
  logic [P_W-1:0]    r_c;
  logic              r_ovf;

  mult_pp_array #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_pp_array (
    .a (a),
    .b (b),
    .p (w_p)
  );

  // Clamp the full product to the output range and flag when the clamp applies.
  always_comb begin
    w_ovf = (w_p > SAT_MAX);
    w_c   = w_p[P_W-1:0];
    if (w_ovf) begin
      w_c = '1;
    end
  end

  // Output register. An asserted reset clears it immediately and drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_c   <= w_c;
      r_ovf <= w_ovf;
    end
  end

  assign c   = r_c;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard testbench for seq_multiplier.
// The driver applies operands on falling edges and queues the expected saturated product.
// The monitor pops and compares one item just after each rising edge.
module tb_seq_multiplier;

  localparam int unsigned A_W = 3;
  localparam int unsigned B_W = 3;
  localparam int unsigned P_W = 5;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned c;
    bit          ovf;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [P_W-1:0] c;
  logic           ovf;

  exp_t exp_q[$];
  int   n_checks;
  int   n_errors;

  seq_multiplier #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer product, clamped to the largest P_W-bit value.
  function automatic exp_t model(input int unsigned av, input int unsigned bv);
    exp_t        e;
    int unsigned full;
    int unsigned lim;
    full  = av * bv;
    lim   = (1 << P_W) - 1;
    e.a   = av;
    e.b   = bv;
    e.ovf = (full > lim);
    e.c   = e.ovf ? lim : full;
    return e;
  endfunction

  task automatic check_zero(input string name);
    n_checks++;
    if (c !== '0 || ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: c=%0d ovf=%0b, required c=0 ovf=0", name, c, ovf);
    end
  endtask

  // Drive one operation on a falling edge and queue the result expected after the next rise.
  task automatic apply(input int unsigned av, input int unsigned bv);
    @(negedge clk);
    a = A_W'(av);
    b = B_W'(bv);
    exp_q.push_back(model(av, bv));
  endtask

  // Monitor: each capture edge that is not in reset must retire exactly one queued result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (c !== P_W'(e.c) || ovf !== e.ovf) begin
        n_errors++;
        $display("FAIL prod a=%0d b=%0d: c=%0d ovf=%0b, required c=%0d ovf=%0b",
                 e.a, e.b, c, ovf, e.c, e.ovf);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    a        = 3'd3;
    b        = 3'd3;

    // Asynchronous reset takes effect before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_hold");

    // Release on a falling edge; the first capture uses the operands present at that rise.
    rst_n = 1'b1;
    exp_q.push_back(model(3, 3));

    // Directed cases: zero operands, small products, the saturation boundary, non-sticky ovf.
    apply(0, 0);
    apply(1, 0);
    apply(2, 2);
    apply(3, 3);
    apply(7, 4);
    apply(6, 6);
    apply(7, 7);
    apply(1, 1);
    apply(0, 7);
    apply(4, 7);
    apply(5, 6);

    // Sweep every operand pair.
    for (int i = 0; i < (1 << A_W); i++) begin
      for (int j = 0; j < (1 << B_W); j++) begin
        apply(i, j);
      end
    end

    // Random traffic.
    for (int k = 0; k < 150; k++) begin
      apply($urandom_range((1 << A_W) - 1), $urandom_range((1 << B_W) - 1));
    end

    // Mid-stream reset between edges: the queued result is dropped and outputs clear at once.
    apply(7, 7);
    #2 rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1 check_zero("reset_mid");
    @(posedge clk);
    #1 check_zero("reset_mid_edge");
    @(negedge clk);
    rst_n = 1'b1;
    a     = 3'd5;
    b     = 3'd5;
    exp_q.push_back(model(5, 5));
    apply(3, 2);
    apply(6, 5);

    // Let the monitor retire the remaining items, then confirm nothing was left behind.
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results pending, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
